// File: rtl/ariane_pkg.sv
// Shared execute-stage constants and the ALU writeback entry format.
package ariane_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [63:0]              result;
    logic                     branch_taken;
  } alu_wb_t;

  function automatic bit is_pow2_min2(int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/alu_wb_buffer_if.sv
// ALU result bus in, scoreboard writeback bus out, seen from the buffer (slave) or its drivers (master).
interface alu_wb_buffer_if #(
  parameter int unsigned TRANS_ID_BITS = 3
);
  logic                     alu_valid_i;
  logic                     alu_ready_o;
  logic [TRANS_ID_BITS-1:0] alu_trans_id_i;
  logic [63:0]              alu_result_i;
  logic                     alu_branch_res_i;
  logic                     alu_is_branch_i;
  logic                     wb_valid_o;
  logic                     wb_ready_i;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
  logic [63:0]              wb_result_o;
  logic                     wb_branch_taken_o;

  modport slave (
    input  alu_valid_i, alu_trans_id_i, alu_result_i, alu_branch_res_i, alu_is_branch_i, wb_ready_i,
    output alu_ready_o, wb_valid_o, wb_trans_id_o, wb_result_o, wb_branch_taken_o
  );

  modport master (
    output alu_valid_i, alu_trans_id_i, alu_result_i, alu_branch_res_i, alu_is_branch_i, wb_ready_i,
    input  alu_ready_o, wb_valid_o, wb_trans_id_o, wb_result_o, wb_branch_taken_o
  );
endinterface

// File: rtl/alu_wb_fifo.sv
// Registered FIFO of DEPTH entries; flush resets pointers/count but leaves storage untouched.
module alu_wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = logic [7:0]
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  T                         data_i,
  input  logic                     pop_i,
  output T                         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  T                r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (pop_i) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;

  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) pop_i |-> !empty_o);
  a_count_max:    assert property (@(posedge clk_i) disable iff (!rst_ni) r_count <= CW'(DEPTH));

endmodule

// File: rtl/alu_wb_buffer.sv
// Buffers ALU results for the scoreboard writeback port; ready to issue only while a slot is free.
module alu_wb_buffer
  import ariane_pkg::alu_wb_t;
  import ariane_pkg::is_pow2_min2;
#(
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned TRANS_ID_BITS = ariane_pkg::TRANS_ID_BITS
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  alu_wb_buffer_if.slave         bus,
  output logic [$clog2(DEPTH):0] occupancy_o
);
  localparam bit CfgOk = is_pow2_min2(DEPTH) && (TRANS_ID_BITS == ariane_pkg::TRANS_ID_BITS);

  logic    w_push;
  logic    w_pop;
  logic    w_full;
  logic    w_empty;
  alu_wb_t w_entry;
  alu_wb_t w_head;

  // Ready and valid come straight from registered count, so no comb path from wb_ready_i / alu_valid_i.
  assign bus.alu_ready_o = ~w_full;
  assign bus.wb_valid_o  = ~w_empty;

  assign w_push = bus.alu_valid_i & ~w_full & ~flush_i;
  assign w_pop  = ~w_empty & bus.wb_ready_i & ~flush_i;

  always_comb begin
    w_entry              = '0;
    w_entry.trans_id     = bus.alu_trans_id_i;
    w_entry.result       = bus.alu_result_i;
    w_entry.branch_taken = bus.alu_branch_res_i & bus.alu_is_branch_i;
  end

  alu_wb_fifo #(
    .DEPTH (DEPTH),
    .T     (alu_wb_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_push),
    .data_i  (w_entry),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (occupancy_o)
  );

  assign bus.wb_trans_id_o     = w_head.trans_id;
  assign bus.wb_result_o       = w_head.result;
  assign bus.wb_branch_taken_o = w_head.branch_taken;

  a_cfg: assert property (@(posedge clk_i) CfgOk);

  // Issue while full is dropped safely; flagged as a protocol violation rather than a hard error.
  a_issue_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.alu_valid_i |-> bus.alu_ready_o)
    else $warning("alu_wb_buffer: issue with no free slot, result dropped");

  a_wb_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.wb_valid_o && !bus.wb_ready_i && !flush_i) |=>
      (bus.wb_valid_o && $stable({bus.wb_trans_id_o, bus.wb_result_o, bus.wb_branch_taken_o})));

endmodule

// File: doc/alu_wb_buffer.md
Name: alu_wb_buffer

Overview:
- Receiving end of the ALU result interface. Registers each ALU result (64-bit result, branch outcome, transaction ID) into a small FIFO and presents it to the scoreboard writeback port with a valid/ready handshake.
- Supplies back-pressure to issue through alu_ready_o, so the combinational ALU can be issued to only when a result slot is free.
- Sits between the ALU in the execute stage and the scoreboard writeback arbiter.

Parameters:
DEPTH, 2, number of buffered results; power of two, at least 2
TRANS_ID_BITS, 3, scoreboard transaction-ID width; matches the shared package constant

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
flush_i  in  1  pipeline flush; discards all buffered and incoming results
alu_valid_i  in  1  ALU result valid this cycle
alu_ready_o  out  1  a free slot exists; issue may dispatch to the ALU
alu_trans_id_i  in  TRANS_ID_BITS  transaction ID of the issued instruction
alu_result_i  in  64  ALU result
alu_branch_res_i  in  1  ALU branch-comparison outcome
alu_is_branch_i  in  1  instruction is a conditional branch
wb_valid_o  out  1  head entry valid
wb_ready_i  in  1  scoreboard accepts the head entry
wb_trans_id_o  out  TRANS_ID_BITS  head transaction ID
wb_result_o  out  64  head result
wb_branch_taken_o  out  1  head branch outcome; forced to 0 when the entry is not a branch
occupancy_o  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (async assert on rst_ni low, sync release): read pointer, write pointer and count all 0.
  - Outputs in reset: wb_valid_o=0, wb_trans_id_o=0, wb_result_o=0, wb_branch_taken_o=0, occupancy_o=0, alu_ready_o=1.
  - Storage array is also reset to 0.
- Push: alu_valid_i & alu_ready_o & ~flush_i.
  - Writes {trans_id, result, branch_res & is_branch} at the write pointer.
  - Write pointer wraps modulo DEPTH.
- Pop: wb_valid_o & wb_ready_i & ~flush_i. Advances the read pointer modulo DEPTH.
- alu_ready_o = (count < DEPTH). It depends only on registered state; there is no combinational path from wb_ready_i or alu_valid_i.
- wb_valid_o = (count != 0). wb_* outputs are driven from the head storage entry.
  - Latency: a result pushed in cycle N is visible on wb_* in cycle N+1. There is no same-cycle bypass, even when the buffer is empty.
  - While wb_valid_o is high and wb_ready_i is low, wb_* stay stable.
  - When wb_valid_o is low, wb_* outputs are don't-care and are not checked by the bench.
- Count update: push only +1; pop only -1; push and pop together leave the count unchanged.
- Full (count=DEPTH): alu_ready_o=0.
  - A simultaneous pop does not raise alu_ready_o in the same cycle; it rises the next cycle.
  - alu_valid_i while full is an issue-protocol violation. Assertion: alu_valid_i -> alu_ready_o.
- Empty plus push: the entry appears next cycle, and a pop cannot happen in that cycle.
- flush_i: next cycle count=0, pointers=0, wb_valid_o=0.
  - A push or pop in the same cycle as flush is ignored.
  - Storage contents are not cleared.
- occupancy_o equals count, registered.
- Assertions:
  - count never exceeds DEPTH.
  - No pop when empty.
  - wb_* stable while stalled.
  - DEPTH is a power of two.

Decomposition:
- ariane_pkg holds TRANS_ID_BITS and a packed struct alu_wb_t {trans_id, result, branch_taken}. The block stores alu_wb_t entries.
- One natural sub-module, alu_wb_fifo: a generic registered FIFO parameterised on DEPTH and the entry type, with push, pop, flush, full, empty and count.
- alu_wb_buffer adds the handshake mapping, the branch masking and the assertions.

Test Plan:
- Reset, then one push {id=3, result=0x0000_0000_DEAD_BEEF, branch_res=1, is_branch=1} with wb_ready_i=1 -> cycle+1 wb_valid_o=1, id=3, result=0x...DEADBEEF, branch_taken=1; cycle+2 wb_valid_o=0.
- Push id=1 with branch_res=1, is_branch=0 -> wb_branch_taken_o=0.
- wb_ready_i=0, push ids 4 then 5 -> occupancy_o=2, alu_ready_o=0; head stays id=4 for 10 cycles. Release wb_ready_i -> pops 4 then 5 in order; alu_ready_o=1 the cycle after the first pop.
- Full buffer, single cycle of pop plus alu_valid_i=1 -> push not accepted, occupancy_o=1 next cycle. The violation assertion must fire.
- Steady stream: alu_valid_i=1 and wb_ready_i=1 every cycle for ids 0..7 -> one result per cycle in order, occupancy_o stays 1 after the first cycle.
- Two entries buffered, flush_i with simultaneous push id=6 -> next cycle wb_valid_o=0, occupancy_o=0; id=6 never appears.
- Assert rst_ni low mid-stream, asynchronously and not on a clock edge -> outputs reach their reset values immediately, without waiting for a clock edge.
